// File: rtl/scroll_sequencer.sv
// scroll_sequencer: frame-paced vertical scroll offset with wrap pulse; optional post-wrap HOLD via SCROLL_HOLD_EN
module scroll_sequencer #(
  parameter int IMG_LINES   = 240,
  parameter int FRAME_DIV   = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       en,
  input  logic       dir,
  input  logic [2:0] step,
  output logic [7:0] position,
  output logic       wrap,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] RUN      = 2'b01;
  localparam logic [1:0] HOLD     = 2'b10;
  localparam logic [8:0] LINES    = 9'(IMG_LINES);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  logic [7:0] div_cnt, div_nxt, pos_nxt, step_eff;
  logic [8:0] sum;
  logic [1:0] state_nxt;
  logic       update, fwd_wrap, rev_wrap, wrap_nxt;
  assign step_eff = (step == 3'd0) ? 8'd1 : {5'd0, step};
  assign sum      = {1'b0, position} + {1'b0, step_eff};
  assign fwd_wrap = sum >= LINES;
  assign rev_wrap = position < step_eff;
  assign update   = en && state == RUN && frame_tick && div_cnt == DIV_LAST;
  assign wrap_nxt = update && (dir ? rev_wrap : fwd_wrap);
  // Reverse wrap uses modulo-256 arithmetic; the result always lands below IMG_LINES.
  assign pos_nxt  = !update ? position :
                    dir     ? (rev_wrap ? position + 8'(IMG_LINES) - step_eff : position - step_eff) :
                              (fwd_wrap ? 8'(sum - LINES) : sum[7:0]);
`ifdef SCROLL_HOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  logic [7:0] hold_cnt, hold_nxt;
  logic       hold_done;
  assign hold_done = en && state == HOLD && frame_tick && hold_cnt == HOLD_LAST;
  // Hold counter only runs inside HOLD; everywhere else it sits at zero.
  always_comb begin
    hold_nxt = (!en || state != HOLD) ? 8'd0 : !frame_tick ? hold_cnt : hold_done ? 8'd0 : hold_cnt + 8'd1;
  end
  // Hold counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt <= 8'd0;
    else hold_cnt <= hold_nxt;
  end
`endif
  // Next-state and frame-divider logic; en=0 overrides everything.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    if (!en) begin
      state_nxt = IDLE;
      div_nxt   = 8'd0;
    end else if (state == IDLE) begin
      state_nxt = RUN;
      div_nxt   = 8'd0;
    end else if (state == RUN && frame_tick) begin
      div_nxt = update ? 8'd0 : div_cnt + 8'd1;
`ifdef SCROLL_HOLD_EN
      state_nxt = wrap_nxt ? HOLD : RUN;
`endif
    end
`ifdef SCROLL_HOLD_EN
    else if (hold_done) begin
      state_nxt = RUN;
      div_nxt   = 8'd0;
    end
`endif
  end
  // Registered outputs and divider state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      position <= 8'd0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      position <= pos_nxt;
      wrap     <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: scoreboard bench for scroll_sequencer (SCROLL_HOLD_EN honoured if defined)
module tb_scroll_sequencer;
  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] tick = '0, en = '0, dir = '0;
  logic [2:0] step0 = '0, step1 = '0;
  logic [7:0] p0, p1;
  logic       w0, w1;
  logic [1:0] st0, st1;
  typedef struct packed {logic [7:0] p; logic w; logic [1:0] st;} exp_t;
  exp_t q[$];
  int vec = 0, bad = 0;
  int m_pos[2], m_st[2], m_div[2], m_hold[2];
  int fd[2] = '{1, 4};
  localparam int HF = 3;
`ifdef SCROLL_HOLD_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif

  scroll_sequencer #(.IMG_LINES(240), .FRAME_DIV(1), .HOLD_FRAMES(HF)) u0 (
    .clk(clk), .rst(rst), .frame_tick(tick[0]), .en(en[0]), .dir(dir[0]), .step(step0),
    .position(p0), .wrap(w0), .state(st0));
  scroll_sequencer #(.IMG_LINES(240), .FRAME_DIV(4), .HOLD_FRAMES(HF)) u1 (
    .clk(clk), .rst(rst), .frame_tick(tick[1]), .en(en[1]), .dir(dir[1]), .step(step1),
    .position(p1), .wrap(w1), .state(st1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    vec++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_st[i] = 0; m_div[i] = 0; m_hold[i] = 0;
    end
  endtask

  // One clock cycle on instance i: drive, predict, push, then pop and compare after the edge.
  task automatic cyc(input int i, input bit e, input bit d, input int s, input bit t);
    exp_t x;
    int se;
    bit w;
    @(negedge clk);
    en[i] = e; dir[i] = d; tick[i] = t;
    if (i == 0) step0 = 3'(s); else step1 = 3'(s);
    se = (s == 0) ? 1 : s;
    w = 1'b0;
    if (!e) begin
      m_st[i] = 0; m_div[i] = 0; m_hold[i] = 0;
    end else if (m_st[i] == 0) begin
      m_st[i] = 1; m_div[i] = 0; m_hold[i] = 0;
    end else if (m_st[i] == 1 && t) begin
      if (m_div[i] == fd[i] - 1) begin
        m_div[i] = 0;
        if (!d) begin
          if (m_pos[i] + se >= 240) begin m_pos[i] = m_pos[i] + se - 240; w = 1'b1; end
          else m_pos[i] = m_pos[i] + se;
        end else begin
          if (m_pos[i] < se) begin m_pos[i] = m_pos[i] + 240 - se; w = 1'b1; end
          else m_pos[i] = m_pos[i] - se;
        end
        if (w && HE) begin m_st[i] = 2; m_hold[i] = 0; end
      end else m_div[i]++;
    end else if (m_st[i] == 2 && t) begin
      if (m_hold[i] == HF - 1) begin m_st[i] = 1; m_div[i] = 0; m_hold[i] = 0; end
      else m_hold[i]++;
    end
    q.push_back('{p: 8'(m_pos[i]), w: w, st: 2'(m_st[i])});
    @(posedge clk);
    #1;
    tick[i] = 1'b0;
    x = q.pop_front();
    vec++;
    assert ((i == 0 ? {p0, w0, st0} : {p1, w1, st1}) === {x.p, x.w, x.st}) else begin
      bad++;
      $error("FAIL cyc%0d: observed pos=%0d wrap=%0b state=%0d expected pos=%0d wrap=%0b state=%0d",
             i, i == 0 ? p0 : p1, i == 0 ? w0 : w1, i == 0 ? st0 : st1, x.p, x.w, x.st);
    end
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    en = '0;
    #1;
    chk({tag, "_pos"}, p0, 0);
    chk({tag, "_wrap"}, w0, 0);
    chk({tag, "_state"}, st0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int hold_st, prev;
    hold_st = HE ? 2 : 1;
    model_reset();
    #1;
    chk("rst_pos", p0, 0);
    chk("rst_wrap", w0, 0);
    chk("rst_state", st0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, 0, 7, 0);
    chk("idle_to_run", st0, 1);
    repeat (19) cyc(0, 1, 0, 7, 1);
    cyc(0, 1, 0, 4, 1);
    chk("pos137", p0, 137);
    async_reset("arst137");
    cyc(0, 1, 0, 7, 0);
    repeat (17) cyc(0, 1, 0, 7, 1);
    cyc(0, 1, 1, 5, 0);
    cyc(0, 1, 1, 2, 0);
    repeat (17) cyc(0, 1, 0, 7, 1);
    chk("pos238", p0, 238);
    cyc(0, 1, 0, 3, 1);
    chk("fwd_wrap_pos", p0, 1);
    chk("fwd_wrap_pulse", w0, 1);
    chk("fwd_wrap_state", st0, hold_st);
    cyc(0, 1, 0, 7, 0);
    chk("wrap_one_cycle", w0, 0);
    repeat (3) cyc(0, 1, 0, 7, 1);
    chk("hold_exit_state", st0, 1);
    chk("hold_frozen_pos", p0, HE ? 1 : 22);
    cyc(0, 1, 0, 7, 1);
    chk("post_hold_update", p0, HE ? 8 : 29);
    async_reset("arst2");
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 1);
    chk("rev_wrap_pos", p0, 239);
    chk("rev_wrap_pulse", w0, 1);
    repeat (3) cyc(0, 1, 1, 0, 1);
    prev = m_pos[0];
    cyc(0, 0, 1, 0, 1);
    chk("freeze_state", st0, 0);
    chk("freeze_wrap", w0, 0);
    chk("freeze_pos", p0, prev);
    cyc(1, 1, 0, 2, 0);
    repeat (20) cyc(1, 1, 0, 2, 1);
    chk("div_start10", p1, 10);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 0, 2, 1);
      if (k == 3) chk("div_tick3", p1, 10);
      if (k == 4) chk("div_tick4", p1, 12);
      if (k == 7) chk("div_tick7", p1, 12);
    end
    chk("div_tick8", p1, 14);
    cyc(1, 1, 0, 2, 1);
    cyc(1, 0, 0, 2, 1);
    cyc(1, 1, 0, 2, 1);
    repeat (3) cyc(1, 1, 0, 2, 1);
    chk("div_restart3", p1, 14);
    cyc(1, 1, 0, 2, 1);
    chk("div_restart4", p1, 16);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
